// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Brief  : MEM-stage load/store responder. Drives a req/ack word memory and
//          stalls the pipeline until the access completes.
//          Optional range check enabled by defining DMEM_BOUNDS_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int          ADDR_W     = 16,
  parameter logic [31:0] DMEM_LIMIT = 32'h0004_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic [31:0]       alu_result_mem,
  input  logic [31:0]       write_data_memory_mem,
  input  logic              alu_ready,
  output logic              data_ready_mem,
  output logic [31:0]       data_from_memory_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              err_oob
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_op;
  logic              w_oob;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_load_data;
  logic              w_unused;

  assign w_op = memread_mem | memwrite_mem;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic r_err_oob;

  assign w_oob = (alu_result_mem >= DMEM_LIMIT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err_oob <= 1'b0;
    end else if (r_state == S_IDLE && w_op && w_oob) begin
      r_err_oob <= 1'b1;
    end
  end

  assign err_oob = r_err_oob;
`else
  assign w_oob   = 1'b0;
  assign err_oob = 1'b0;
`endif

  // Address bits outside the word index, and the limit, matter only in some builds
  assign w_unused = ^{alu_result_mem, DMEM_LIMIT};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_op) begin
          w_state_nxt = w_oob ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (alu_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    data_ready_mem = 1'b0;
    case (r_state)
      S_IDLE:  data_ready_mem = ~w_op;
      S_DONE:  data_ready_mem = 1'b1;
      default: data_ready_mem = 1'b0;
    endcase
  end

  // Bus fields are captured once at launch; acks outside BUSY are stale and dropped
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_op && w_oob) begin
            if (!memwrite_mem) begin
              r_load_data <= '0;
            end
          end else if (w_op) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= memwrite_mem;
            r_mem_addr  <= alu_result_mem[ADDR_W+1:2];
            r_mem_wdata <= write_data_memory_mem;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_load_data <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req              = r_mem_req;
  assign mem_we               = r_mem_we;
  assign mem_addr             = r_mem_addr;
  assign mem_wdata            = r_mem_wdata;
  assign data_from_memory_mem = r_load_data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_responder
// Brief  : Scoreboard bench for dmem_responder with a random-latency memory.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          wait_cyc;
  } req_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
  } done_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        memread_mem, memwrite_mem, alu_ready;
  logic [31:0] alu_result_mem, write_data_memory_mem;
  logic        data_ready_mem;
  logic [31:0] data_from_memory_mem;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err_oob;

  int          total = 0;
  int          bad   = 0;
  bit          resp_en;
  logic [31:0] last_load;
  logic        err_exp;
  req_t        req_q[$];
  done_t       done_q[$];
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] env_mem[int unsigned];

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .memread_mem          (memread_mem),
    .memwrite_mem         (memwrite_mem),
    .alu_result_mem       (alu_result_mem),
    .write_data_memory_mem(write_data_memory_mem),
    .alu_ready            (alu_ready),
    .data_ready_mem       (data_ready_mem),
    .data_from_memory_mem (data_from_memory_mem),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_ack              (mem_ack),
    .mem_rdata            (mem_rdata),
    .err_oob              (err_oob)
  );

  function automatic logic [31:0] init_val(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input int wt, input int hold);
    done_t       d;
    int unsigned w;
    bit          oob;
    int          n;
    w   = (a / 4) % 65536;
    oob = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    oob = (a >= 32'h0004_0000);
`endif
    if (oob) begin
      d.lat   = 1;
      err_exp = 1'b1;
      if (!wr) last_load = 32'h0;
    end else begin
      d.lat = 2 + wt;
      req_q.push_back('{we: wr, addr: w[15:0], wdata: wd, wait_cyc: wt});
      if (wr) ref_mem[w] = wd;
      else    last_load = ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    end
    d.data = last_load;
    done_q.push_back(d);
    memread_mem           = rd;
    memwrite_mem          = wr;
    alu_result_mem        = a;
    write_data_memory_mem = wd;
    alu_ready             = (hold == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (data_ready_mem !== 1'b1 && n < 100);
    chk("ready_timeout", 32'(data_ready_mem), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ready", 32'(data_ready_mem), 32'd1);
      chk("hold_data", data_from_memory_mem, last_load);
      chk("hold_noreq", 32'(mem_req), 32'd0);
    end
    alu_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    memread_mem  = 1'b0;
    memwrite_mem = 1'b0;
    alu_ready    = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Memory model: answers each request after its scheduled wait
  initial begin : responder
    req_t r;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (rstn === 1'b1 && mem_req === 1'b1) begin
          total++;
          if (req_q.size() == 0) begin
            bad++;
            $display("FAIL spurious_req: got mem_req=1 addr=%h expected no request", mem_addr);
          end else begin
            r = req_q.pop_front();
            chk("req_we", 32'(mem_we), 32'(r.we));
            chk("req_addr", 32'(mem_addr), 32'(r.addr));
            chk("req_wdata", mem_wdata, r.wdata);
            for (int i = 0; i < r.wait_cyc; i++) begin
              @(negedge clk);
              chk("req_hold", 32'(mem_req), 32'd1);
            end
            if (mem_we) env_mem[32'(mem_addr)] = mem_wdata;
            else mem_rdata = env_mem.exists(32'(mem_addr)) ? env_mem[32'(mem_addr)]
                                                            : init_val(32'(mem_addr));
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk("req_drop", 32'(mem_req), 32'd0);
          end
        end
      end
    end
  end

  // Counts stall cycles and checks each completion against the scoreboard
  initial begin : monitor
    int    cnt;
    done_t d;
    cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rstn !== 1'b1) begin
        cnt = 0;
      end else if (data_ready_mem !== 1'b1) begin
        cnt++;
      end else if (cnt > 0) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_done: got completion after %0d stall cycles expected none", cnt);
        end else begin
          d = done_q.pop_front();
          chk("stall_cycles", 32'(cnt), 32'(d.lat));
          chk("load_data", data_from_memory_mem, d.data);
        end
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : stim
    logic rd, wr;
    rstn                  = 1'b0;
    memread_mem           = 1'b0;
    memwrite_mem          = 1'b0;
    alu_result_mem        = 32'h0;
    write_data_memory_mem = 32'h0;
    alu_ready             = 1'b1;
    resp_en               = 1'b1;
    last_load             = 32'h0;
    err_exp               = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_data", data_from_memory_mem, 32'h0);
    chk("rst_err", 32'(err_oob), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(data_ready_mem), 32'd1);

    do_op(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0);
    do_op(1'b1, 1'b0, 32'h0000_0100, 32'h1111_2222, 5, 0);
    do_op(1'b1, 1'b0, 32'h0000_0103, 32'h3333_4444, 1, 3);
    do_op(1'b1, 1'b0, 32'h0000_0200, 32'h0, 2, 0);
    do_op(1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 0, 0);
    do_op(1'b1, 1'b1, 32'h0000_0204, 32'h0BAD_F00D, 1, 0);
    do_op(1'b1, 1'b0, 32'h0000_0204, 32'h0, 0, 0);
    do_op(1'b0, 1'b1, 32'h0004_0108, 32'h5A5A_1234, 0, 0);
    do_op(1'b1, 1'b0, 32'h0000_0108, 32'h0, 0, 1);
    idle(2);

    for (int k = 0; k < 40; k++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      do_op(rd, wr,
            (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3) | (($urandom & 32'h1) << 18),
            $urandom, $urandom_range(0, 4), $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    resp_en        = 1'b0;
    mem_ack        = 1'b0;
    memread_mem    = 1'b1;
    alu_result_mem = 32'h0000_0300;
    @(negedge clk);
    chk("busy_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rstn        = 1'b0;
    memread_mem = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_data", data_from_memory_mem, 32'h0);
    @(negedge clk);
    rstn      = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stale_ack_data", data_from_memory_mem, 32'h0);
    chk("stale_ack_req", 32'(mem_req), 32'd0);
    chk("stale_ack_ready", 32'(data_ready_mem), 32'd1);
    last_load = 32'h0;
    err_exp   = 1'b0;
    resp_en   = 1'b1;
    @(negedge clk);
    do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 0);

`ifdef DMEM_BOUNDS_CHECK_EN
    do_op(1'b1, 1'b0, 32'h0004_0000, 32'h0, 0, 0);
    chk("oob_err_set", 32'(err_oob), 32'd1);
    do_op(1'b0, 1'b1, 32'h0000_0010, 32'h7777_8888, 0, 0);
`endif
    idle(4);
    chk("err_oob_final", 32'(err_oob), 32'(err_exp));
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
